// File: rtl/axi_region_remapper.sv
// axi_region_remapper
//   Remaps AXI4 AW/AR addresses through a runtime-programmable table of
//   NUM_REGIONS base/mask/offset windows. The lowest matching index wins, and
//   an address that matches nothing passes through unchanged. AW and AR each
//   pass through a 2-entry skid slice, which gives 1-cycle latency and full
//   throughput. W, B and R are wired straight through.
//
//   Optional feature: define REMAP_MISS_LOG_EN to add miss logging ports
//   (err_valid, err_addr, err_is_write, err_count, err_clr).
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   s_axi_aw*/m_axi_aw* AW channel; m_axi_awaddr is the remapped address
//   s_axi_ar*/m_axi_ar* AR channel; m_axi_araddr is the remapped address
//   s/m_axi_w*,b*,r*    combinational passthrough
//   cfg_we/idx/valid/base/mask/offset  table write port, one entry per cycle
//   err_*               miss log (REMAP_MISS_LOG_EN only)
`timescale 1ns/1ps

// Two-entry (main + skid) register slice. s_ready depends only on state,
// never on m_ready.
module axi_region_remapper_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  typedef enum logic [1:0] {SL_EMPTY, SL_ONE, SL_TWO} occ_t;

  occ_t             state, state_n;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             cap, drain;
  logic             load_main_in, load_main_skid, load_skid;

  assign s_ready = (state != SL_TWO);
  assign m_valid = (state != SL_EMPTY);
  assign m_data  = main_data;
  assign cap     = s_valid && (state != SL_TWO);
  assign drain   = (state != SL_EMPTY) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SL_EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      SL_EMPTY: begin
        if (cap) begin
          load_main_in = 1'b1;
          state_n      = SL_ONE;
        end
      end
      SL_ONE: begin
        // Capture while draining replaces main in place.
        if (cap && drain) begin
          load_main_in = 1'b1;
        end else if (cap) begin
          load_skid = 1'b1;
          state_n   = SL_TWO;
        end else if (drain) begin
          state_n = SL_EMPTY;
        end
      end
      SL_TWO: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_n        = SL_ONE;
        end
      end
      default: state_n = SL_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in)        main_data <= s_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= s_data;
    end
  end
endmodule

module axi_region_remapper #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 64,
  parameter  int ID_WIDTH    = 1,
  parameter  int NUM_REGIONS = 4,
  localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // AW
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // W
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // B
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AR
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // R
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // Table configuration
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic                    cfg_valid,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_mask,
  input  logic [ADDR_WIDTH-1:0]   cfg_offset
`ifdef REMAP_MISS_LOG_EN
  ,
  output logic                    err_valid,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    err_is_write,
  output logic [15:0]             err_count,
  input  logic                    err_clr
`endif
);
  localparam int PW = ADDR_WIDTH + ID_WIDTH + 13;

  // Region table
  logic                  tbl_valid  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] tbl_base   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] tbl_mask   [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0] tbl_offset [NUM_REGIONS];

  // Indices >= NUM_REGIONS never compare equal, so such writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_base[i]   <= '0;
        tbl_mask[i]   <= '0;
        tbl_offset[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          tbl_valid[i]  <= cfg_valid;
          tbl_base[i]   <= cfg_base;
          tbl_mask[i]   <= cfg_mask;
          tbl_offset[i] <= cfg_offset;
        end
      end
    end
  end

  // Translation reads the registered table, so a write in the capture cycle
  // only affects later captures.
  function automatic logic [ADDR_WIDTH-1:0] remap_addr(input logic [ADDR_WIDTH-1:0] a);
    logic                  hit;
    logic [ADDR_WIDTH-1:0] r;
    hit = 1'b0;
    r   = a;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!hit && tbl_valid[i] && ((a & tbl_mask[i]) == (tbl_base[i] & tbl_mask[i]))) begin
        hit = 1'b1;
        r   = (a & ~tbl_mask[i]) | (tbl_offset[i] & tbl_mask[i]);
      end
    end
    return r;
  endfunction

  logic [ADDR_WIDTH-1:0] aw_remap, ar_remap;
  logic [PW-1:0]         aw_in, aw_out, ar_in, ar_out;

  assign aw_remap = remap_addr(s_axi_awaddr);
  assign ar_remap = remap_addr(s_axi_araddr);
  assign aw_in    = {aw_remap, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst};
  assign ar_in    = {ar_remap, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst};

  axi_region_remapper_slice #(.WIDTH(PW)) u_aw_slice (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_axi_awvalid),
    .s_ready (s_axi_awready),
    .s_data  (aw_in),
    .m_valid (m_axi_awvalid),
    .m_ready (m_axi_awready),
    .m_data  (aw_out)
  );

  axi_region_remapper_slice #(.WIDTH(PW)) u_ar_slice (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_axi_arvalid),
    .s_ready (s_axi_arready),
    .s_data  (ar_in),
    .m_valid (m_axi_arvalid),
    .m_ready (m_axi_arready),
    .m_data  (ar_out)
  );

  assign {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_out;
  assign {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst} = ar_out;

  // Passthrough channels
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wvalid = s_axi_wvalid;
  assign s_axi_wready = m_axi_wready;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;

  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;

`ifdef REMAP_MISS_LOG_EN
  function automatic logic region_hit(input logic [ADDR_WIDTH-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (tbl_valid[i] && ((a & tbl_mask[i]) == (tbl_base[i] & tbl_mask[i]))) hit = 1'b1;
    end
    return hit;
  endfunction

  logic                  aw_miss, ar_miss;
  logic                  err_valid_n, err_is_write_n;
  logic [ADDR_WIDTH-1:0] err_addr_n;
  logic [15:0]           err_count_n;

  assign aw_miss = s_axi_awvalid && s_axi_awready && !region_hit(s_axi_awaddr);
  assign ar_miss = s_axi_arvalid && s_axi_arready && !region_hit(s_axi_araddr);

  // Clear is applied first so a same-cycle miss lands in the cleared log;
  // AW is folded in before AR so it wins the latch when both miss.
  always_comb begin
    err_valid_n    = err_clr ? 1'b0 : err_valid;
    err_addr_n     = err_clr ? '0   : err_addr;
    err_is_write_n = err_clr ? 1'b0 : err_is_write;
    err_count_n    = err_clr ? '0   : err_count;
    if (aw_miss) begin
      if (err_count_n != 16'hFFFF) err_count_n = err_count_n + 16'd1;
      if (!err_valid_n) begin
        err_valid_n    = 1'b1;
        err_addr_n     = s_axi_awaddr;
        err_is_write_n = 1'b1;
      end
    end
    if (ar_miss) begin
      if (err_count_n != 16'hFFFF) err_count_n = err_count_n + 16'd1;
      if (!err_valid_n) begin
        err_valid_n    = 1'b1;
        err_addr_n     = s_axi_araddr;
        err_is_write_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
      err_count    <= '0;
    end else begin
      err_valid    <= err_valid_n;
      err_addr     <= err_addr_n;
      err_is_write <= err_is_write_n;
      err_count    <= err_count_n;
    end
  end
`endif
endmodule
